// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg: FSM encodings and sizing helper shared by mux_n_reg.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_n_reg_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick: first valid channel scanning ptr, ptr+1, ... modulo CHANNELS.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    pick,
  output logic                any
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

  logic [SEL_W:0] idx;

  // Scan from the farthest offset down so the nearest valid channel wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (SEL_W+1)'(i);
      if (idx >= CH_LIM) idx = idx - CH_LIM;
      if (valid[idx[SEL_W-1:0]]) begin
        pick = idx[SEL_W-1:0];
        any  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_n_reg.sv
// ----------------------------------------------------------------------------
// mux_n_reg: N-input registered mux with valid/ready handshake and tagging.
// Optional round-robin selection when MUX_RR_EN is defined.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_n_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  output logic [CNT_W-1:0]          xfer_cnt
);

  logic [0:0]       state;
  logic [SEL_W-1:0] chan;
  logic             chan_ok;
  logic             can_accept;
  logic             capture;
  logic [WIDTH-1:0] data_sel;

`ifdef MUX_RR_EN
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] ptr;
  logic             any_valid;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .valid (in_valid),
    .ptr   (ptr),
    .pick  (chan),
    .any   (any_valid)
  );

  assign chan_ok = any_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (capture) begin
      ptr <= (chan == LAST) ? '0 : chan + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= 1'b0;
  end
`else
  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

  assign chan    = sel;
  assign chan_ok = ({1'b0, sel} < CH_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= !chan_ok && (|in_valid);
  end
`endif

  // A held beat leaving this cycle frees the register for a new one.
  assign can_accept = (state == ST_IDLE) || out_ready;

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_ready
      assign in_ready[k] = chan_ok && can_accept && (chan == SEL_W'(k));
    end
  endgenerate

  assign capture   = |(in_valid & in_ready);
  assign out_valid = (state == ST_HOLD);

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan == SEL_W'(i)) data_sel = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      out_data <= '0;
      out_chan <= '0;
      xfer_cnt <= '0;
    end else begin
      if (capture) begin
        out_data <= data_sel;
        out_chan <= chan;
        xfer_cnt <= xfer_cnt + CNT_W'(1);
        state    <= ST_HOLD;
      end else if (out_ready) begin
        state    <= ST_IDLE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_n_reg.sv
// ----------------------------------------------------------------------------
// tb_mux_n_reg: directed bench for mux_n_reg (N=4/CNT_W=16 and N=3/CNT_W=4).
// Build with MUX_RR_EN defined to exercise the round-robin configuration.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mux_n_reg;

  localparam int NA = 4;
  localparam int NB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [1:0]  a_sel, a_out_chan;
  logic [7:0]  a_out_data;
  logic        a_out_valid, a_out_ready, a_sel_err;
  logic [15:0] a_xfer_cnt;

  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_out_chan;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_ready, b_sel_err;
  logic [3:0]  b_xfer_cnt;

  mux_n_reg #(.WIDTH(8), .CHANNELS(NA), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data), .out_chan(a_out_chan),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .sel_err(a_sel_err),
    .xfer_cnt(a_xfer_cnt)
  );

  mux_n_reg #(.WIDTH(8), .CHANNELS(NB), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data), .out_chan(b_out_chan),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err),
    .xfer_cnt(b_xfer_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the consumer must see, derived from the transfer rules.
  typedef struct {
    bit         valid;
    logic [7:0] data;
    int         chan;
    int         cnt;
    bit         err;
    int         ptr;
  } m_t;

  function automatic m_t m_zero();
    m_t r;
    r.valid = 0; r.data = 8'h00; r.chan = 0; r.cnt = 0; r.err = 0; r.ptr = 0;
    return r;
  endfunction

  function automatic int choose(input int n, input logic [3:0] valid, input int sel,
                                input int ptr, output bit ok);
    int c;
    c  = 0;
    ok = 0;
`ifdef MUX_RR_EN
    for (int i = 0; i < n; i++) begin
      if (!ok && valid[(ptr + i) % n]) begin
        ok = 1;
        c  = (ptr + i) % n;
      end
    end
`else
    ok = (sel < n);
    c  = sel;
`endif
    return c;
  endfunction

  function automatic m_t step(input m_t s, input int n, input int cmask, input logic [31:0] data,
                              input logic [3:0] valid, input int sel, input bit ordy);
    m_t r;
    bit ok;
    int c;
    r = s;
    c = choose(n, valid, sel, s.ptr, ok);
    r.err = 0;
`ifndef MUX_RR_EN
    r.err = (sel >= n) && (valid != 4'b0);
`endif
    if (ok && (!s.valid || ordy) && valid[c]) begin
      r.valid = 1;
      r.data  = data[c*8 +: 8];
      r.chan  = c;
      r.cnt   = (s.cnt + 1) & cmask;
      r.ptr   = (c + 1) % n;
    end else if (ordy) begin
      r.valid = 0;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_rdy(input m_t s, input int n, input logic [3:0] valid,
                                         input int sel);
    logic [3:0] r;
    bit ok;
    int c;
    r = 4'b0;
    c = choose(n, valid, sel, s.ptr, ok);
    if (ok && (!s.valid || a_dummy_room(s))) r[c] = 1'b1;
    return r;
  endfunction

  // Room check needs the instance's out_ready; resolved by the callers below.
  bit room_a, room_b, room_sel;
  function automatic bit a_dummy_room(input m_t s);
    return room_sel;
  endfunction

  m_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= m_zero();
      mb <= m_zero();
    end else begin
      ma <= step(ma, NA, 32'hFFFF, a_in_data, a_in_valid, int'(a_sel), a_out_ready);
      mb <= step(mb, NB, 32'hF, {8'h00, b_in_data}, {1'b0, b_in_valid}, int'(b_sel), b_out_ready);
    end
  end

  always @(negedge clk) begin
    chk("a_out_valid", {31'b0, a_out_valid}, {31'b0, ma.valid});
    chk("a_out_data", {24'b0, a_out_data}, {24'b0, ma.data});
    chk("a_out_chan", {30'b0, a_out_chan}, ma.chan);
    chk("a_xfer_cnt", {16'b0, a_xfer_cnt}, ma.cnt);
    chk("a_sel_err", {31'b0, a_sel_err}, {31'b0, ma.err});
    room_sel = a_out_ready;
    chk("a_in_ready", {28'b0, a_in_ready}, {28'b0, exp_rdy(ma, NA, a_in_valid, int'(a_sel))});
    chk("b_out_valid", {31'b0, b_out_valid}, {31'b0, mb.valid});
    chk("b_out_data", {24'b0, b_out_data}, {24'b0, mb.data});
    chk("b_out_chan", {30'b0, b_out_chan}, mb.chan);
    chk("b_xfer_cnt", {28'b0, b_xfer_cnt}, mb.cnt);
    chk("b_sel_err", {31'b0, b_sel_err}, {31'b0, mb.err});
    room_sel = b_out_ready;
    chk("b_in_ready", {28'b0, 1'b0, b_in_ready},
        {28'b0, exp_rdy(mb, NB, {1'b0, b_in_valid}, int'(b_sel))});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_a_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_a_cnt", {16'b0, a_xfer_cnt}, 32'd0);
    chk("rst_a_err", {31'b0, a_sel_err}, 32'd0);
    chk("rst_b_cnt", {28'b0, b_xfer_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Counter wrap: 17 beats on a 4-bit counter
    b_sel = 2'd0; b_out_ready = 1'b1; b_in_valid = 3'b001;
    for (int i = 0; i < 17; i++) begin
      b_in_data = 24'($urandom);
      tick();
    end
    chk("wrap_b_cnt", {28'b0, b_xfer_cnt}, 32'd1);
    b_in_valid = 3'b000;
    tick();

`ifndef MUX_RR_EN
    // Single beat from ch2
    a_sel = 2'd2; a_in_data = 32'h00A5_0000; a_in_valid = 4'b0100; a_out_ready = 1'b1;
    tick();
    a_in_valid = 4'b0000;
    chk("t2_data", {24'b0, a_out_data}, 32'hA5);
    chk("t2_chan", {30'b0, a_out_chan}, 32'd2);
    chk("t2_valid", {31'b0, a_out_valid}, 32'd1);
    chk("t2_cnt", {16'b0, a_xfer_cnt}, 32'd1);
    tick();
    chk("t2_drain", {31'b0, a_out_valid}, 32'd0);

    // Backpressure then back-to-back release
    a_sel = 2'd1; a_in_data = 32'h0000_1100; a_in_valid = 4'b0010; a_out_ready = 1'b0;
    tick();
    a_sel = 2'd2; a_in_data = 32'h003C_0000; a_in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ready_low", {28'b0, a_in_ready}, 32'd0);
      chk("t3_stable", {24'b0, a_out_data}, 32'h11);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("t3_ready_hi", {28'b0, a_in_ready}, 32'b0100);
    tick();
    chk("t3_data", {24'b0, a_out_data}, 32'h3C);
    chk("t3_nobubble", {31'b0, a_out_valid}, 32'd1);
    chk("t3_cnt", {16'b0, a_xfer_cnt}, 32'd3);
    a_in_valid = 4'b0000;
    tick();

    // Non-selected valid channels are ignored
    a_sel = 2'd0; a_in_valid = 4'b1110; a_in_data = 32'hDEAD_BEEF;
    tick(); tick();
    chk("ign_cnt", {16'b0, a_xfer_cnt}, 32'd3);

    // Throughput with a changing select
    a_in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      a_sel = 2'(i % 4);
      a_in_data = $urandom;
      tick();
    end
    a_in_valid = 4'b0000;
    tick();

    // Out-of-range select on the 3-channel instance
    b_sel = 2'd3; b_in_valid = 3'b111; b_in_data = 24'h123456; b_out_ready = 1'b1;
    #1;
    chk("t4_ready", {29'b0, b_in_ready}, 32'd0);
    tick();
    chk("t4_err", {31'b0, b_sel_err}, 32'd1);
    chk("t4_cnt", {28'b0, b_xfer_cnt}, 32'd1);
    b_in_valid = 3'b000;
    tick();
    chk("t4_err_clr", {31'b0, b_sel_err}, 32'd0);

    // A held beat drains while select is out of range
    b_sel = 2'd1; b_in_valid = 3'b010; b_out_ready = 1'b0;
    tick();
    b_sel = 2'd3; b_in_valid = 3'b111;
    tick();
    chk("drain_hold", {31'b0, b_out_valid}, 32'd1);
    chk("drain_err", {31'b0, b_sel_err}, 32'd1);
    b_out_ready = 1'b1;
    tick();
    chk("drain_done", {31'b0, b_out_valid}, 32'd0);
    b_in_valid = 3'b000;
    tick();
`else
    // Round-robin over all four channels, then over ch1/ch3 only
    a_in_valid = 4'b1111; a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_in_data = $urandom;
      tick();
      chk("rr_all", {30'b0, a_out_chan}, 32'(i % 4));
    end
    a_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_odd", {30'b0, a_out_chan}, (i % 2 == 0) ? 32'd3 : 32'd1);
    end
    a_in_valid = 4'b0000;
    tick();
`endif

    // Asynchronous reset while a beat is held
    a_sel = 2'd1; a_in_data = 32'h0000_7700; a_in_valid = 4'b0010; a_out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, a_out_valid}, 32'd0);
    chk("arst_data", {24'b0, a_out_data}, 32'd0);
    chk("arst_chan", {30'b0, a_out_chan}, 32'd0);
    chk("arst_cnt", {16'b0, a_xfer_cnt}, 32'd0);
    chk("arst_b_cnt", {28'b0, b_xfer_cnt}, 32'd0);
    a_in_valid = 4'b0000;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
